// File: rtl/mem_access_ctrl_pkg.sv
// Shared CPU types for the memory-stage access controller.
// FSM encoding and the word-alignment constant.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memctl_state_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// EX/MEM fields, dcache handshake and MEM/WB-side outputs
// of the memory-stage access controller.
interface memory_access_if #(
    parameter int WORD_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic              halt_in;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] store_data;
    logic              advance;
    logic              flush;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic [WORD_W-1:0] dload_out;
    logic              mem_done;
    logic              mem_stall;
    logic              misalign;
    logic              halted;

    modport ctrl (
        input  mem_read, mem_write, halt_in, addr, store_data,
        input  advance, flush, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dload_out, mem_done, mem_stall, misalign, halted
    );

    modport tb (
        output mem_read, mem_write, halt_in, addr, store_data,
        output advance, flush, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dload_out, mem_done, mem_stall, misalign, halted
    );

endinterface

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage dcache access controller feeding the MEM/WB latch.
// Issues each load/store once and generates the memory stall.
module mem_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    memory_access_if.ctrl      bus,
    output logic [CNT_W-1:0]   stall_cycles
);

    memctl_state_t     state;
    memctl_state_t     nxt;
    logic [WORD_W-1:0] dload_reg;
    logic              pend_flush;
    logic              halted_r;

    logic is_mem;
    logic misal;
    logic acc;
    logic busy;
    logic discard;
    logic capture;

    always_comb begin
        is_mem  = bus.mem_read | bus.mem_write;
        misal   = is_mem & (bus.addr[1:0] != WORD_ALIGN_MASK);
        acc     = is_mem & ~misal & ~halted_r;
        busy    = 1'b0;
        unique case (state)
            IDLE:    busy = acc & ~bus.flush;
            // a started handshake must finish even if squashed
            REQ:     busy = acc | pend_flush;
            default: busy = 1'b0;
        endcase
        discard = (state == REQ) & (pend_flush | bus.flush);
        capture = busy & bus.dhit & ~discard;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (busy) begin
                    if (!bus.dhit)       nxt = REQ;
                    else if (bus.advance) nxt = IDLE;
                    else                  nxt = DONE;
                end
            end
            REQ: begin
                if (bus.dhit) begin
                    if (discard || bus.advance) nxt = IDLE;
                    else                        nxt = DONE;
                end
            end
            DONE: begin
                if (bus.advance || bus.flush) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            dload_reg  <= '0;
            pend_flush <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state <= nxt;
            if (capture) begin
                dload_reg <= bus.dmemload;
            end
            if (state == REQ && bus.dhit) begin
                pend_flush <= 1'b0;
            end else if (state == REQ && bus.flush) begin
                pend_flush <= 1'b1;
            end
            if (bus.halt_in && bus.advance && !bus.flush) begin
                halted_r <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.dmemREN   = busy & bus.mem_read;
        bus.dmemWEN   = busy & bus.mem_write;
        bus.dmemaddr  = busy ? bus.addr : '0;
        bus.dmemstore = busy ? bus.store_data : '0;
        bus.dload_out = capture ? bus.dmemload : dload_reg;
        bus.mem_done  = (state == DONE) | ~busy | bus.dhit;
        bus.mem_stall = busy & ~bus.dhit;
        bus.misalign  = misal;
        bus.halted    = halted_r;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (bus.mem_stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: handshake, hold, flush,
// misalign, halt, reset and stall-counter saturation.
module tb_mem_access_ctrl;
    import cpu_types_pkg::*;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 8;

    logic             CLK;
    logic             nRST;
    logic [CNT_W-1:0] stall_cycles;
    logic             tie;
    logic             adv;
    int               n_assert;
    int               n_fail;
    int               rq;

    memory_access_if #(.WORD_W(WORD_W)) bus ();

    assign bus.advance = tie ? ~bus.mem_stall : adv;

    mem_access_ctrl #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .bus          (bus),
        .stall_cycles (stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.halt_in    = 1'b0;
        bus.addr       = '0;
        bus.store_data = '0;
        bus.flush      = 1'b0;
        bus.dhit       = 1'b0;
        bus.dmemload   = '0;
        tie            = 1'b0;
        adv            = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        nRST     = 1'b0;
        idle_in();
        tick();
        tick();
        #1;
        chk("rst_ren",   bus.dmemREN, 1'b0);
        chk("rst_stall", bus.mem_stall, 1'b0);
        chk("rst_cnt",   stall_cycles, 8'd0);
        chk("rst_done",  bus.mem_done, 1'b1);
        chk("rst_dload", bus.dload_out, 32'd0);
        nRST = 1'b1;
        tick();

        // LW 0x40, dhit in third cycle, advance = ~stall
        bus.mem_read = 1'b1;
        bus.addr     = 32'h40;
        tie          = 1'b1;
        #1;
        chk("lw_c1_ren",   bus.dmemREN, 1'b1);
        chk("lw_c1_stall", bus.mem_stall, 1'b1);
        tick();
        chk("lw_c2_state", dut.state, REQ);
        chk("lw_c2_ren",   bus.dmemREN, 1'b1);
        chk("lw_c2_stall", bus.mem_stall, 1'b1);
        chk("lw_c2_addr",  bus.dmemaddr, 32'h40);
        tick();
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hDEADBEEF;
        #1;
        chk("lw_c3_ren",   bus.dmemREN, 1'b1);
        chk("lw_c3_stall", bus.mem_stall, 1'b0);
        chk("lw_c3_dload", bus.dload_out, 32'hDEADBEEF);
        chk("lw_c3_done",  bus.mem_done, 1'b1);
        tick();
        idle_in();
        #1;
        chk("lw_state", dut.state, IDLE);
        chk("lw_cnt",   stall_cycles, 8'd2);
        chk("lw_hold",  bus.dload_out, 32'hDEADBEEF);

        // SW 0x44 with same-cycle dhit
        bus.mem_write  = 1'b1;
        bus.addr       = 32'h44;
        bus.store_data = 32'h12345678;
        bus.dhit       = 1'b1;
        adv            = 1'b1;
        #1;
        chk("sw_wen",   bus.dmemWEN, 1'b1);
        chk("sw_ren",   bus.dmemREN, 1'b0);
        chk("sw_addr",  bus.dmemaddr, 32'h44);
        chk("sw_data",  bus.dmemstore, 32'h12345678);
        chk("sw_stall", bus.mem_stall, 1'b0);
        tick();
        chk("sw_state", dut.state, IDLE);
        idle_in();

        // LW with dhit while the pipeline is held
        bus.mem_read = 1'b1;
        bus.addr     = 32'h48;
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hCAFEF00D;
        adv          = 1'b0;
        #1;
        rq = 0;
        rq += int'(bus.dmemREN);
        chk("hold_c1_dload", bus.dload_out, 32'hCAFEF00D);
        chk("hold_c1_stall", bus.mem_stall, 1'b0);
        tick();
        bus.dhit     = 1'b0;
        bus.dmemload = 32'h0BADBAD0;
        for (int i = 0; i < 3; i++) begin
            #1;
            rq += int'(bus.dmemREN);
            chk("hold_state", dut.state, DONE);
            chk("hold_ren",   bus.dmemREN, 1'b0);
            chk("hold_stall", bus.mem_stall, 1'b0);
            chk("hold_done",  bus.mem_done, 1'b1);
            chk("hold_dload", bus.dload_out, 32'hCAFEF00D);
            tick();
        end
        chk("hold_one_req", rq, 1);
        adv = 1'b1;
        tick();
        chk("hold_exit", dut.state, IDLE);
        idle_in();

        // flush in REQ, dhit two cycles later
        bus.mem_read = 1'b1;
        bus.addr     = 32'h4C;
        tie          = 1'b1;
        tick();
        chk("fl_req", dut.state, REQ);
        bus.flush = 1'b1;
        #1;
        chk("fl_c2_ren",   bus.dmemREN, 1'b1);
        chk("fl_c2_stall", bus.mem_stall, 1'b1);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fl_c3_ren",   bus.dmemREN, 1'b1);
        chk("fl_c3_stall", bus.mem_stall, 1'b1);
        tick();
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h11111111;
        #1;
        chk("fl_c4_stall", bus.mem_stall, 1'b0);
        tick();
        idle_in();
        #1;
        chk("fl_state", dut.state, IDLE);
        chk("fl_dload", bus.dload_out, 32'hCAFEF00D);
        chk("fl_stall", bus.mem_stall, 1'b0);
        chk("fl_cnt",   stall_cycles, 8'd5);

        // reset while in REQ
        bus.mem_read = 1'b1;
        bus.addr     = 32'h54;
        adv          = 1'b0;
        tick();
        chk("rq_state", dut.state, REQ);
        chk("rq_cnt",   stall_cycles, 8'd6);
        nRST = 1'b0;
        idle_in();
        tick();
        chk("rq_rst_state", dut.state, IDLE);
        chk("rq_rst_ren",   bus.dmemREN, 1'b0);
        chk("rq_rst_stall", bus.mem_stall, 1'b0);
        chk("rq_rst_cnt",   stall_cycles, 8'd0);
        chk("rq_rst_dload", bus.dload_out, 32'd0);
        chk("rq_rst_halt",  bus.halted, 1'b0);
        nRST = 1'b1;

        // long stall to saturate the counter
        bus.mem_read = 1'b1;
        bus.addr     = 32'h58;
        adv          = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        chk("sat_254", stall_cycles, 8'd254);
        tick();
        chk("sat_255", stall_cycles, 8'd255);
        for (int i = 0; i < 40; i++) tick();
        chk("sat_hold", stall_cycles, 8'd255);
        chk("sat_ren",  bus.dmemREN, 1'b1);
        bus.dhit = 1'b1;
        adv      = 1'b1;
        tick();
        idle_in();

        // misaligned load
        bus.mem_read = 1'b1;
        bus.addr     = 32'h41;
        #1;
        chk("mis_flag",  bus.misalign, 1'b1);
        chk("mis_ren",   bus.dmemREN, 1'b0);
        chk("mis_stall", bus.mem_stall, 1'b0);
        tick();
        idle_in();

        // halt passes to WB, later LW is ignored
        bus.halt_in = 1'b1;
        adv         = 1'b1;
        tick();
        idle_in();
        #1;
        chk("halt_set", bus.halted, 1'b1);
        bus.mem_read = 1'b1;
        bus.addr     = 32'h60;
        #1;
        chk("halt_ren",   bus.dmemREN, 1'b0);
        chk("halt_stall", bus.mem_stall, 1'b0);
        tick();
        chk("halt_sticky", bus.halted, 1'b1);
        idle_in();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
